// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: sequences ALU, register file, PC and the shared memory
// port one instruction at a time, with a bounded wait on mem_ready.
module multicycle_controller #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic       retire,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;

  logic       r_legal;
  logic [3:0] r_alu_op;
  logic       limit_hit;

  logic       pc_write_c, pc_src_c, ir_write_c, i_or_d_c, mem_read_c, mem_write_c;
  logic       mem_to_reg_c, reg_dst_c, reg_write_c, alu_src_a_c, retire_c;
  logic [1:0] alu_src_b_c;
  logic [3:0] alu_op_c;

  // R-type funct decode shared by DECODE (legality) and EXEC (ALU control)
  always_comb begin
    r_legal  = 1'b1;
    r_alu_op = ALU_ADD;
    case (funct)
      FN_ADD:  r_alu_op = ALU_ADD;
      FN_SUB:  r_alu_op = ALU_SUB;
      FN_AND:  r_alu_op = ALU_AND;
      FN_OR:   r_alu_op = ALU_OR;
      FN_SLT:  r_alu_op = ALU_SLT;
      default: r_legal  = 1'b0;
    endcase
  end

  assign limit_hit = (cnt_q == CNT_W'(WAIT_LIMIT)) && !mem_ready;

  // State register, wait counter and sticky flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state and control decode; the counter only survives while a memory
  // state keeps waiting, so every entry into a wait state starts from zero.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    illegal_d    = illegal_q;
    timeout_d    = timeout_q;
    pc_write_c   = 1'b0;
    pc_src_c     = 1'b0;
    ir_write_c   = 1'b0;
    i_or_d_c     = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_dst_c    = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = SRCB_REG;
    alu_op_c     = ALU_AND;
    retire_c     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = SRCB_FOUR;
        alu_op_c    = ALU_ADD;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (limit_hit) begin
          timeout_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DECODE: begin
        alu_src_b_c = SRCB_BR;
        alu_op_c    = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_RTYPE: begin
            if (r_legal) begin
              state_d = S_EXEC;
            end else begin
              illegal_d = 1'b1;
              state_d   = S_FETCH;
            end
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        alu_op_c    = ALU_ADD;
        state_d     = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (limit_hit) begin
          timeout_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_MEM_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        retire_c     = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (limit_hit) begin
          timeout_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_REG;
        alu_op_c    = r_alu_op;
        state_d     = S_R_WB;
      end

      S_R_WB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_REG;
        alu_op_c    = ALU_SUB;
        pc_src_c    = 1'b1;
        pc_write_c  = zero;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end

      S_ADDI_EX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        alu_op_c    = ALU_ADD;
        state_d     = S_ADDI_WB;
      end

      S_ADDI_WB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

  // Reset forces every control line low, including the FETCH read request
  assign pc_write    = pc_write_c   & ~reset;
  assign pc_src      = pc_src_c     & ~reset;
  assign ir_write    = ir_write_c   & ~reset;
  assign i_or_d      = i_or_d_c     & ~reset;
  assign mem_read    = mem_read_c   & ~reset;
  assign mem_write   = mem_write_c  & ~reset;
  assign mem_to_reg  = mem_to_reg_c & ~reset;
  assign reg_dst     = reg_dst_c    & ~reset;
  assign reg_write   = reg_write_c  & ~reset;
  assign alu_src_a   = alu_src_a_c  & ~reset;
  assign alu_src_b   = reset ? 2'b00 : alu_src_b_c;
  assign alu_op      = reset ? 4'b0000 : alu_op_c;
  assign retire      = retire_c     & ~reset;
  assign illegal_op  = illegal_q    & ~reset;
  assign mem_timeout = timeout_q    & ~reset;
  assign state       = reset ? 4'd0 : 4'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-accurate bench for multicycle_controller: per-cycle stimulus and expected
// control words are queued, then driven and compared cycle by cycle.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcs, irw, iod, mr, mw, m2r, rd, rw, asa;
    logic [1:0] asb;
    logic [3:0] aop;
    logic       ret, ill, tmo;
  } obs_t;

  typedef struct packed {
    logic       rst, rdy, z;
    logic [5:0] opc, fn;
    obs_t       e;
  } stim_t;

  // ctl bit order: pcw pcs irw iod mr mw m2r rd rw asa
  function automatic obs_t mk(input logic [3:0] st, input logic [9:0] ctl,
                              input logic [1:0] asb, input logic [3:0] aop, input logic ret);
    mk = {st, ctl, asb, aop, ret, 2'b00};
  endfunction

  localparam obs_t E_ZERO   = mk(4'd0,  10'b0000000000, 2'b00, 4'b0000, 1'b0);
  localparam obs_t E_FWAIT  = mk(4'd0,  10'b0000100000, 2'b01, 4'b0010, 1'b0);
  localparam obs_t E_FGO    = mk(4'd0,  10'b1010100000, 2'b01, 4'b0010, 1'b0);
  localparam obs_t E_DEC    = mk(4'd1,  10'b0000000000, 2'b11, 4'b0010, 1'b0);
  localparam obs_t E_MADDR  = mk(4'd2,  10'b0000000001, 2'b10, 4'b0010, 1'b0);
  localparam obs_t E_MRD    = mk(4'd3,  10'b0001100000, 2'b00, 4'b0000, 1'b0);
  localparam obs_t E_MWB    = mk(4'd4,  10'b0000001010, 2'b00, 4'b0000, 1'b1);
  localparam obs_t E_MWRW   = mk(4'd5,  10'b0001010000, 2'b00, 4'b0000, 1'b0);
  localparam obs_t E_MWRGO  = mk(4'd5,  10'b0001010000, 2'b00, 4'b0000, 1'b1);
  localparam obs_t E_EXSLT  = mk(4'd6,  10'b0000000001, 2'b00, 4'b0111, 1'b0);
  localparam obs_t E_EXSUB  = mk(4'd6,  10'b0000000001, 2'b00, 4'b0110, 1'b0);
  localparam obs_t E_RWB    = mk(4'd7,  10'b0000000110, 2'b00, 4'b0000, 1'b1);
  localparam obs_t E_BRZ    = mk(4'd8,  10'b1100000001, 2'b00, 4'b0110, 1'b1);
  localparam obs_t E_BRNZ   = mk(4'd8,  10'b0100000001, 2'b00, 4'b0110, 1'b1);
  localparam obs_t E_AEX    = mk(4'd9,  10'b0000000001, 2'b10, 4'b0010, 1'b0);
  localparam obs_t E_AWB    = mk(4'd10, 10'b0000000010, 2'b00, 4'b0000, 1'b1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_BAD  = 6'b000000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a, retire, illegal_op, mem_timeout;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op, state;
  obs_t       obs;

  stim_t sb[$];
  logic  exp_ill = 1'b0, exp_tmo = 1'b0;
  int    n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.WAIT_LIMIT(3), .CNT_W(4)) dut (
    .clk(clk), .reset(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .retire(retire), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .state(state)
  );

  assign obs = {state, pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, retire, illegal_op, mem_timeout};

  task automatic push(input logic r, input logic rdy, input logic z,
                      input logic [5:0] opc, input logic [5:0] fn, input obs_t e);
    stim_t s;
    s.rst = r; s.rdy = rdy; s.z = z; s.opc = opc; s.fn = fn;
    s.e = e;
    s.e.ill = exp_ill;
    s.e.tmo = exp_tmo;
    sb.push_back(s);
  endtask

  task automatic test_reset();
    stim_t c;
    exp_ill = 1'b0; exp_tmo = 1'b0;
    push(1, 0, 0, OP_LW, FN_BAD, E_ZERO);
    push(1, 1, 1, OP_LW, FN_BAD, E_ZERO);
    for (int k = 0; sb.size() != 0; k++) begin
      c = sb.pop_front();
      rst = c.rst; mem_ready = c.rdy; zero = c.z; opcode = c.opc; funct = c.fn;
      #1;
      n_cmp++;
      if (obs !== c.e) begin
        n_err++;
        $display("FAIL reset step %0d: got st=%0d word=%h, expected st=%0d word=%h", k, obs.st, obs, c.e.st, c.e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw();
    stim_t c;
    push(0, 0, 0, OP_LW, FN_BAD, E_FWAIT);
    push(0, 0, 0, OP_LW, FN_BAD, E_FWAIT);
    push(0, 1, 0, OP_LW, FN_BAD, E_FGO);
    push(0, 0, 0, OP_LW, FN_BAD, E_DEC);
    push(0, 0, 0, OP_LW, FN_BAD, E_MADDR);
    push(0, 0, 0, OP_LW, FN_BAD, E_MRD);
    push(0, 0, 0, OP_LW, FN_BAD, E_MRD);
    push(0, 1, 0, OP_LW, FN_BAD, E_MRD);
    push(0, 0, 0, OP_LW, FN_BAD, E_MWB);
    for (int k = 0; sb.size() != 0; k++) begin
      c = sb.pop_front();
      rst = c.rst; mem_ready = c.rdy; zero = c.z; opcode = c.opc; funct = c.fn;
      #1;
      n_cmp++;
      if (obs !== c.e) begin
        n_err++;
        $display("FAIL lw_wait step %0d: got st=%0d word=%h, expected st=%0d word=%h", k, obs.st, obs, c.e.st, c.e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_beq();
    stim_t c;
    push(0, 1, 0, OP_BEQ, FN_BAD, E_FGO);
    push(0, 0, 1, OP_BEQ, FN_BAD, E_DEC);
    push(0, 0, 1, OP_BEQ, FN_BAD, E_BRZ);
    push(0, 1, 1, OP_BEQ, FN_BAD, E_FGO);
    push(0, 0, 0, OP_BEQ, FN_BAD, E_DEC);
    push(0, 0, 0, OP_BEQ, FN_BAD, E_BRNZ);
    for (int k = 0; sb.size() != 0; k++) begin
      c = sb.pop_front();
      rst = c.rst; mem_ready = c.rdy; zero = c.z; opcode = c.opc; funct = c.fn;
      #1;
      n_cmp++;
      if (obs !== c.e) begin
        n_err++;
        $display("FAIL beq step %0d: got st=%0d word=%h, expected st=%0d word=%h", k, obs.st, obs, c.e.st, c.e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rtype();
    stim_t c;
    push(0, 1, 0, OP_R, FN_SLT, E_FGO);
    push(0, 0, 0, OP_R, FN_SLT, E_DEC);
    push(0, 0, 0, OP_R, FN_SLT, E_EXSLT);
    push(0, 0, 0, OP_R, FN_SLT, E_RWB);
    push(0, 1, 0, OP_R, FN_SUB, E_FGO);
    push(0, 0, 0, OP_R, FN_SUB, E_DEC);
    push(0, 0, 0, OP_R, FN_SUB, E_EXSUB);
    push(0, 0, 0, OP_R, FN_SUB, E_RWB);
    for (int k = 0; sb.size() != 0; k++) begin
      c = sb.pop_front();
      rst = c.rst; mem_ready = c.rdy; zero = c.z; opcode = c.opc; funct = c.fn;
      #1;
      n_cmp++;
      if (obs !== c.e) begin
        n_err++;
        $display("FAIL rtype step %0d: got st=%0d word=%h, expected st=%0d word=%h", k, obs.st, obs, c.e.st, c.e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal_opcode();
    stim_t c;
    push(0, 1, 0, OP_J, FN_BAD, E_FGO);
    push(0, 0, 0, OP_J, FN_BAD, E_DEC);
    exp_ill = 1'b1;
    push(0, 1, 0, OP_ADDI, FN_BAD, E_FGO);
    push(0, 0, 0, OP_ADDI, FN_BAD, E_DEC);
    push(0, 0, 0, OP_ADDI, FN_BAD, E_AEX);
    push(0, 0, 0, OP_ADDI, FN_BAD, E_AWB);
    for (int k = 0; sb.size() != 0; k++) begin
      c = sb.pop_front();
      rst = c.rst; mem_ready = c.rdy; zero = c.z; opcode = c.opc; funct = c.fn;
      #1;
      n_cmp++;
      if (obs !== c.e) begin
        n_err++;
        $display("FAIL illegal_opcode step %0d: got st=%0d word=%h, expected st=%0d word=%h", k, obs.st, obs, c.e.st, c.e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    stim_t c;
    // ready arrives exactly in the limit cycle: normal completion
    push(0, 1, 0, OP_SW, FN_BAD, E_FGO);
    push(0, 0, 0, OP_SW, FN_BAD, E_DEC);
    push(0, 0, 0, OP_SW, FN_BAD, E_MADDR);
    push(0, 0, 0, OP_SW, FN_BAD, E_MWRW);
    push(0, 0, 0, OP_SW, FN_BAD, E_MWRW);
    push(0, 0, 0, OP_SW, FN_BAD, E_MWRW);
    push(0, 1, 0, OP_SW, FN_BAD, E_MWRGO);
    push(0, 1, 0, OP_SW, FN_BAD, E_FGO);
    push(0, 0, 0, OP_SW, FN_BAD, E_DEC);
    push(0, 0, 0, OP_SW, FN_BAD, E_MADDR);
    push(0, 0, 0, OP_SW, FN_BAD, E_MWRW);
    push(0, 0, 0, OP_SW, FN_BAD, E_MWRW);
    push(0, 0, 0, OP_SW, FN_BAD, E_MWRW);
    push(0, 0, 0, OP_SW, FN_BAD, E_MWRW);
    exp_tmo = 1'b1;
    push(0, 0, 0, OP_SW, FN_BAD, E_FWAIT);
    for (int k = 0; sb.size() != 0; k++) begin
      c = sb.pop_front();
      rst = c.rst; mem_ready = c.rdy; zero = c.z; opcode = c.opc; funct = c.fn;
      #1;
      n_cmp++;
      if (obs !== c.e) begin
        n_err++;
        $display("FAIL timeout step %0d: got st=%0d word=%h, expected st=%0d word=%h", k, obs.st, obs, c.e.st, c.e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    stim_t c;
    push(0, 1, 0, OP_SW, FN_BAD, E_FGO);
    push(0, 0, 0, OP_SW, FN_BAD, E_DEC);
    push(0, 0, 0, OP_SW, FN_BAD, E_MADDR);
    push(0, 0, 0, OP_SW, FN_BAD, E_MWRW);
    exp_ill = 1'b0; exp_tmo = 1'b0;
    push(1, 0, 0, OP_SW, FN_BAD, E_ZERO);
    push(1, 1, 0, OP_SW, FN_BAD, E_ZERO);
    push(0, 0, 0, OP_SW, FN_BAD, E_FWAIT);
    for (int k = 0; sb.size() != 0; k++) begin
      c = sb.pop_front();
      rst = c.rst; mem_ready = c.rdy; zero = c.z; opcode = c.opc; funct = c.fn;
      #1;
      n_cmp++;
      if (obs !== c.e) begin
        n_err++;
        $display("FAIL mid_reset step %0d: got st=%0d word=%h, expected st=%0d word=%h", k, obs.st, obs, c.e.st, c.e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal_funct();
    stim_t c;
    push(0, 1, 0, OP_R, FN_BAD, E_FGO);
    push(0, 0, 0, OP_R, FN_BAD, E_DEC);
    exp_ill = 1'b1;
    push(0, 0, 0, OP_R, FN_BAD, E_FWAIT);
    for (int k = 0; sb.size() != 0; k++) begin
      c = sb.pop_front();
      rst = c.rst; mem_ready = c.rdy; zero = c.z; opcode = c.opc; funct = c.fn;
      #1;
      n_cmp++;
      if (obs !== c.e) begin
        n_err++;
        $display("FAIL illegal_funct step %0d: got st=%0d word=%h, expected st=%0d word=%h", k, obs.st, obs, c.e.st, c.e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_lw();
    test_beq();
    test_rtype();
    test_illegal_opcode();
    test_timeout();
    test_mid_reset();
    test_illegal_funct();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
